// File: rtl/pu_shift_multi.sv
// Accumulator shifter for the shared PU bus: logical/arithmetic/rotate, iterative SHIFT_PER_CYCLE bits per clock.
// Define PU_SHIFT_BARREL_EN for a single-cycle barrel variant (busy tied low).
module pu_shift_multi #(
    parameter int DATA_WIDTH      = 32,
    parameter int ATTR_WIDTH      = 4,
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_init,
    input  logic                  signal_load_amount,
    input  logic                  signal_work,
    input  logic                  signal_direction,
    input  logic                  signal_mode,
    input  logic                  signal_rotate,
    input  logic                  signal_oe,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    output logic                  busy
);

    localparam int AMT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [AMT_WIDTH:0] DW = (AMT_WIDTH+1)'(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] acc;
    logic [AMT_WIDTH-1:0]  amount;
    logic                  carry;
    logic                  ovf;
    logic                  zero;
    logic [DATA_WIDTH+1:0] shift_res;

    logic unused_attr;
    assign unused_attr = ^attr_in;

    // Returns {overflow, carry, result} for a k-bit shift (1 <= k < DATA_WIDTH).
    // Overflow: top k+1 bits of the operand not all equal (arithmetic left only).
    function automatic logic [DATA_WIDTH+1:0] do_shift(
        input logic [DATA_WIDTH-1:0] a,
        input logic [AMT_WIDTH:0]    k,
        input logic                  left,
        input logic                  arith,
        input logic                  rot
    );
        logic [DATA_WIDTH-1:0] r;
        logic [DATA_WIDTH-1:0] co_l;
        logic [DATA_WIDTH-1:0] co_r;
        logic [DATA_WIDTH-1:0] sx;
        logic                  c;
        logic                  v;
        co_l = a >> (DW - k);
        co_r = a >> (k - 1'b1);
        if (left) begin
            r = rot ? ((a << k) | (a >> (DW - k))) : (a << k);
            c = co_l[0];
        end else begin
            if (rot)
                r = (a >> k) | (a << (DW - k));
            else if (arith)
                r = $signed(a) >>> k;
            else
                r = a >> k;
            c = co_r[0];
        end
        sx = $signed(a) >>> (DW - 1'b1 - k);
        v  = left && arith && !rot && !((sx == '0) || (&sx));
        return {v, c, r};
    endfunction

`ifdef PU_SHIFT_BARREL_EN

    always_comb begin
        shift_res = do_shift(acc, {1'b0, amount}, signal_direction,
                             signal_mode, signal_rotate);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            amount <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else if (signal_init) begin
            acc   <= data_in;
            carry <= 1'b0;
            ovf   <= 1'b0;
            zero  <= (data_in == '0);
        end else if (signal_load_amount) begin
            amount <= data_in[AMT_WIDTH-1:0];
        end else if (signal_work) begin
            if (amount == '0) begin
                carry <= 1'b0;
                ovf   <= 1'b0;
                zero  <= (acc == '0);
            end else begin
                acc   <= shift_res[DATA_WIDTH-1:0];
                carry <= shift_res[DATA_WIDTH];
                ovf   <= shift_res[DATA_WIDTH+1];
                zero  <= (shift_res[DATA_WIDTH-1:0] == '0);
            end
        end
    end

    assign busy = 1'b0;

`else

    localparam logic [0:0]           ST_IDLE  = 1'b0;
    localparam logic [0:0]           ST_SHIFT = 1'b1;
    localparam logic [AMT_WIDTH-1:0] SPC      = AMT_WIDTH'(SHIFT_PER_CYCLE);

    logic [0:0]           state;
    logic [AMT_WIDTH-1:0] remaining;
    logic [AMT_WIDTH-1:0] step_n;
    logic                 dir_q;
    logic                 mode_q;
    logic                 rot_q;

    always_comb begin
        step_n    = (remaining < SPC) ? remaining : SPC;
        shift_res = do_shift(acc, {1'b0, step_n}, dir_q, mode_q, rot_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            amount    <= '0;
            remaining <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            dir_q     <= 1'b0;
            mode_q    <= 1'b0;
            rot_q     <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (signal_init) begin
                acc   <= data_in;
                carry <= 1'b0;
                ovf   <= 1'b0;
                zero  <= (data_in == '0);
            end else if (signal_load_amount) begin
                amount <= data_in[AMT_WIDTH-1:0];
            end else if (signal_work) begin
                carry <= 1'b0;
                ovf   <= 1'b0;
                if (amount == '0) begin
                    zero <= (acc == '0);
                end else begin
                    dir_q     <= signal_direction;
                    mode_q    <= signal_mode;
                    rot_q     <= signal_rotate;
                    remaining <= amount;
                    state     <= ST_SHIFT;
                end
            end
        end else begin
            // Overflow is sticky across chunks: any chunk seeing unequal top bits taints the op.
            acc       <= shift_res[DATA_WIDTH-1:0];
            carry     <= shift_res[DATA_WIDTH];
            ovf       <= ovf | shift_res[DATA_WIDTH+1];
            zero      <= (shift_res[DATA_WIDTH-1:0] == '0);
            remaining <= remaining - step_n;
            if (remaining == step_n)
                state <= ST_IDLE;
        end
    end

    assign busy = (state == ST_SHIFT);

`endif

    always_comb begin
        attr_out = '0;
        data_out = '0;
        if (signal_oe) begin
            data_out    = acc;
            attr_out[0] = carry;
            attr_out[1] = ovf;
            attr_out[2] = zero;
            attr_out[3] = busy;
        end
    end

endmodule

// File: tb/tb_pu_shift_multi.sv
// Randomised and directed bench for pu_shift_multi against a bit-at-a-time reference model.
module tb_pu_shift_multi;

`ifdef PU_SHIFT_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        signal_init;
    logic        signal_load_amount;
    logic        signal_work;
    logic        signal_direction;
    logic        signal_mode;
    logic        signal_rotate;
    logic        signal_oe;
    logic [31:0] data_in;
    logic [3:0]  attr_in;
    logic [31:0] data_out;
    logic [3:0]  attr_out;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pu_shift_multi #(
        .DATA_WIDTH(32),
        .ATTR_WIDTH(4),
        .SHIFT_PER_CYCLE(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .signal_init(signal_init),
        .signal_load_amount(signal_load_amount),
        .signal_work(signal_work),
        .signal_direction(signal_direction),
        .signal_mode(signal_mode),
        .signal_rotate(signal_rotate),
        .signal_oe(signal_oe),
        .data_in(data_in),
        .attr_in(attr_in),
        .data_out(data_out),
        .attr_out(attr_out),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One bit per step; carry is the bit pushed out, overflow any sign flip during arithmetic left.
    task automatic model(input logic [31:0] op, input int amt, input logic left,
                         input logic arith, input logic rot,
                         output logic [31:0] res, output logic c, output logic v);
        logic out_bit;
        logic in_bit;
        res = op;
        c   = 1'b0;
        v   = 1'b0;
        for (int s = 0; s < amt; s++) begin
            if (left) begin
                out_bit = res[31];
                in_bit  = rot ? out_bit : 1'b0;
                res     = {res[30:0], in_bit};
                if (arith && !rot && (res[31] != out_bit))
                    v = 1'b1;
            end else begin
                out_bit = res[0];
                in_bit  = rot ? out_bit : (arith ? res[31] : 1'b0);
                res     = {in_bit, res[31:1]};
            end
            c = out_bit;
        end
    endtask

    task automatic run_op(input logic [31:0] op, input int amt, input logic left,
                          input logic arith, input logic rot, input string tag);
        logic [31:0] er;
        logic        ec;
        logic        ev;
        int          cyc;
        int          exp_cyc;
        model(op, amt, left, arith, rot, er, ec, ev);
        signal_oe = 1'b0;
        data_in = op;
        signal_init = 1'b1;
        tick();
        signal_init = 1'b0;
        data_in = 32'(amt);
        signal_load_amount = 1'b1;
        tick();
        signal_load_amount = 1'b0;
        signal_direction = left;
        signal_mode      = arith;
        signal_rotate    = rot;
        signal_work      = 1'b1;
        tick();
        signal_work = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            signal_direction = 1'($urandom);
            signal_mode      = 1'($urandom);
            signal_rotate    = 1'($urandom);
            data_in          = $urandom;
            tick();
            cyc++;
        end
        exp_cyc = BARREL ? 0 : amt;
        check({tag, "_busy_cycles"}, 32'(cyc), 32'(exp_cyc));
        signal_oe = 1'b1;
        #1;
        check({tag, "_data"}, data_out, er);
        check({tag, "_attr"}, 32'(attr_out), {28'b0, 1'b0, (er == 32'b0), ev, ec});
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        signal_init = 1'b0;
        signal_load_amount = 1'b0;
        signal_work = 1'b0;
        signal_direction = 1'b0;
        signal_mode = 1'b0;
        signal_rotate = 1'b0;
        signal_oe = 1'b1;
        data_in = '0;
        attr_in = '0;
        tick();
        tick();
        check("reset_data", data_out, 32'h0);
        check("reset_attr", 32'(attr_out), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick();

        run_op(32'h0000_0010, 1, 1'b1, 1'b1, 1'b0, "s1");
        check("s1_const", data_out, 32'h0000_0020);
        run_op(32'hFFFF_FFF0, 4, 1'b0, 1'b1, 1'b0, "s2a");
        check("s2a_const", data_out, 32'hFFFF_FFFF);
        run_op(32'hFFFF_FFF0, 4, 1'b0, 1'b0, 1'b0, "s2l");
        check("s2l_const", data_out, 32'h0FFF_FFFF);
        run_op(32'h8000_0001, 1, 1'b1, 1'b0, 1'b1, "s3r");
        check("s3r_const", data_out, 32'h0000_0003);
        check("s3r_carry", 32'(attr_out[0]), 32'h1);
        run_op(32'h8000_0001, 1, 1'b0, 1'b0, 1'b0, "s3l");
        check("s3l_const", data_out, 32'h4000_0000);
        check("s3l_carry", 32'(attr_out[0]), 32'h1);
        run_op(32'h4000_0000, 1, 1'b1, 1'b1, 1'b0, "s4a");
        check("s4a_ovf", 32'(attr_out[1]), 32'h1);
        run_op(32'hC000_0000, 1, 1'b1, 1'b1, 1'b0, "s4b");
        check("s4b_const", data_out, 32'h8000_0000);
        check("s4b_ovf", 32'(attr_out[1]), 32'h0);

        signal_oe = 1'b0;
        #1;
        check("s6_oe_data", data_out, 32'h0);
        check("s6_oe_attr", 32'(attr_out), 32'h0);

        if (!BARREL) begin
            // Init command during busy must be ignored.
            signal_oe = 1'b0;
            data_in = 32'h1; signal_init = 1'b1; tick(); signal_init = 1'b0;
            data_in = 32'd8; signal_load_amount = 1'b1; tick(); signal_load_amount = 1'b0;
            signal_direction = 1'b1; signal_mode = 1'b0; signal_rotate = 1'b0;
            signal_work = 1'b1; tick(); signal_work = 1'b0;
            tick();
            tick();
            data_in = 32'h0000_AAAA; signal_init = 1'b1; tick(); signal_init = 1'b0;
            cyc = 3;
            while (busy === 1'b1 && cyc < 100) begin
                tick();
                cyc++;
            end
            check("s5_busy_cycles", 32'(cyc), 32'd8);
            signal_oe = 1'b1;
            #1;
            check("s5_data", data_out, 32'h0000_0100);

            signal_oe = 1'b0;
            data_in = 32'h1; signal_init = 1'b1; tick(); signal_init = 1'b0;
            data_in = 32'd8; signal_load_amount = 1'b1; tick(); signal_load_amount = 1'b0;
            signal_work = 1'b1; tick(); signal_work = 1'b0;
            tick();
            tick();
            check("s5_busy_mid", 32'(busy), 32'h1);
            rst = 1'b1; #2; rst = 1'b0; #1;
            signal_oe = 1'b1;
            #1;
            check("s5_rst_busy", 32'(busy), 32'h0);
            check("s5_rst_data", data_out, 32'h0);
            tick();
            check("s5_rst_stays_idle", 32'(busy), 32'h0);
        end

        // Zero amount: no busy, accumulator unchanged, carry/overflow cleared.
        signal_oe = 1'b1;
        data_in = 32'h0000_1234; signal_init = 1'b1; tick(); signal_init = 1'b0;
        data_in = 32'h0; signal_load_amount = 1'b1; tick(); signal_load_amount = 1'b0;
        signal_direction = 1'b1; signal_mode = 1'b1; signal_rotate = 1'b0;
        signal_work = 1'b1; tick(); signal_work = 1'b0;
        check("s6_amt0_busy", 32'(busy), 32'h0);
        check("s6_amt0_data", data_out, 32'h0000_1234);
        check("s6_amt0_attr", 32'(attr_out), 32'h0);
        data_in = 32'h0; signal_init = 1'b1; tick(); signal_init = 1'b0;
        check("s6_zero_attr", 32'(attr_out), 32'h4);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] op;
            op = $urandom;
            if (i % 3 == 0) op = op | 32'hF000_0000;
            if (i % 5 == 0) op = op & 32'h0000_FFFF;
            run_op(op, int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
                   1'($urandom), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pu_shift_multi.md
Name: pu_shift_multi

Overview:
- Parametrised successor to the single-step processing-unit shifter.
- Accumulator-based shifter with a programmable shift amount, logical, arithmetic and rotate modes, and iterative multi-cycle execution (SHIFT_PER_CYCLE bits per clock) with a busy flag.
- Sits on the shared PU data bus: outputs are zero unless output-enabled, so several PUs can be OR-combined.
- Attribute outputs report carry, overflow, zero and busy.

Parameters:
- DATA_WIDTH, 32, accumulator and data bus width; power of two, >= 8.
- ATTR_WIDTH, 4, attribute bus width; >= 4, upper bits beyond 3 read 0.
- SHIFT_PER_CYCLE, 1, bits shifted per SHIFT-state clock; 1..DATA_WIDTH-1.
- Localparam AMT_WIDTH = $clog2(DATA_WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- signal_init  input  1  load data_in into accumulator.
- signal_load_amount  input  1  load data_in[AMT_WIDTH-1:0] into amount register.
- signal_work  input  1  start a shift of amount bits.
- signal_direction  input  1  1 = left, 0 = right.
- signal_mode  input  1  1 = arithmetic, 0 = logical; ignored when signal_rotate = 1.
- signal_rotate  input  1  1 = rotate.
- signal_oe  input  1  drive data_out and attr_out.
- data_in  input  DATA_WIDTH  operand or amount.
- attr_in  input  ATTR_WIDTH  reserved; ignored.
- data_out  output  DATA_WIDTH  accumulator when signal_oe = 1, else 0.
- attr_out  output  ATTR_WIDTH  flags when signal_oe = 1, else 0.
- busy  output  1  high while in SHIFT.

Behaviour:
- Reset (async): acc = 0, amount = 0, remaining = 0, flags = 0, state = IDLE, busy = 0, so data_out and attr_out read 0.
- FSM states: IDLE and SHIFT.
- IDLE priority, per edge: signal_init > signal_load_amount > signal_work. Only the highest-priority command executes; the others are dropped.
- IDLE, signal_init: acc <= data_in; carry and overflow cleared; zero = (data_in == 0).
- IDLE, signal_work with amount = 0: no state change, acc unchanged, carry and overflow cleared, zero updated.
- IDLE, signal_work with amount > 0:
  - latch direction, mode and rotate;
  - remaining <= amount; clear carry and overflow;
  - go to SHIFT. No data moves on this edge.
- SHIFT, each edge:
  - shift acc by n = min(remaining, SHIFT_PER_CYCLE); remaining -= n;
  - when remaining reaches 0, return to IDLE.
  - Total busy cycles = ceil(amount / SHIFT_PER_CYCLE). Result is valid in the first cycle busy = 0.
- Fill rules:
  - logical: zero fill.
  - arithmetic right: sign fill.
  - arithmetic left: zero fill.
  - rotate: wrapped bits re-enter at the opposite end.
- Flags (attr_out bits):
  - bit0 carry = last bit shifted out (for rotate, the last bit that wrapped).
  - bit1 overflow = arithmetic-left only; sticky, set if the sign bit changes at any single-bit position during the operation, i.e. the top amount+1 bits of the original operand are not all equal. Otherwise 0.
  - bit2 zero = (acc == 0), updated with acc.
  - bit3 busy.
- While in SHIFT, signal_init, signal_load_amount and signal_work are ignored. Control inputs are latched at start, so changes mid-operation have no effect.
- signal_oe is combinational in every state. A read while busy returns the partial accumulator; reads are legal but the value is undefined for software.
- Reset asserted mid-SHIFT aborts immediately to reset values.

Optional Feature:
- Macro: PU_SHIFT_BARREL_EN.
- Defined: single-cycle barrel shifter.
  - signal_work with any amount updates acc and flags on the same edge.
  - State stays IDLE; busy is tied 0; SHIFT_PER_CYCLE is ignored.
  - Results and flags are identical to the iterative version.
- Undefined: iterative behaviour as above.

Test Plan:
All scenarios use DATA_WIDTH = 32, SHIFT_PER_CYCLE = 1.
1. init 0x10; amount 1; work arith-left; oe -> busy high 1 cycle; data_out 0x00000020; attr carry 0, ovf 0, zero 0.
2. init 0xFFFFFFF0; amount 4; work arith-right -> busy high exactly 4 cycles; data_out 0xFFFFFFFF; carry 0. Repeat logical-right -> 0x0FFFFFFF.
3. init 0x80000001; amount 1:
   - rotate-left -> 0x00000003, carry 1.
   - re-init; logical-right -> 0x40000000, carry 1.
4. init 0x40000000; amount 1; arith-left -> 0x80000000, ovf 1. Then init 0xC0000000, amount 1, arith-left -> 0x80000000, ovf 0.
5. init 0x1; amount 8; work; assert init 0xAAAA during cycle 3 of busy -> ignored, result 0x00000100. Rerun and pulse rst in cycle 3 -> busy 0, data_out 0 with oe.
6. signal_oe = 0 after any operation -> data_out 0, attr_out 0. amount 0 with work -> busy never rises, acc unchanged. init 0 -> zero flag 1.
   - With PU_SHIFT_BARREL_EN, repeat scenarios 1-4 -> same values, busy constantly 0, result after one edge.
